// File: rtl/wb_sram_burst_reader.sv
// Burst read initiator for the 32-bit port of a dual-port SRAM responder.
// It streams a block of consecutive words through a small credit-managed FIFO
// to a valid/ready consumer.
module wb_sram_burst_reader #(
   parameter int SBITS = 10,
   parameter int ASB   = SBITS - 1,
   parameter int LBITS = SBITS + 1,
   parameter int FBITS = 2,
   parameter int DEPTH = 1 << FBITS
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [SBITS-1:0] base_i,
   input  logic [LBITS-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic             bst_o,
   input  logic             ack_i,
   input  logic             wat_i,
   output logic [ASB:0]     adr_o,
   input  logic [31:0]      dat_i,
   output logic [31:0]      dat_o,
   output logic             vld_o,
   input  logic             rdy_i
);

   typedef enum logic {IDLE, BUS} state_t;

   state_t             state_q, state_d;
   logic [ASB:0]       adr_q, adr_d;
   logic [LBITS-1:0]   len_q, len_d;
   logic [LBITS-1:0]   iss_q, iss_d;     // requests accepted by the responder
   logic [LBITS-1:0]   acks_q, acks_d;   // words returned
   logic [FBITS:0]     out_q, out_d;     // requests accepted but not yet acked
   logic               zdone_q, zdone_d; // done pulse for a zero-length start
   logic [FBITS-1:0]   wptr_q, wptr_d;
   logic [FBITS-1:0]   rptr_q, rptr_d;
   logic [FBITS:0]     cnt_q, cnt_d;
   logic [31:0]        mem_q [DEPTH];

   logic               in_bus, credit, stb, accept, push, pop, last_ack;

   // Handshake decode. A strobe needs a credit: words in flight plus words
   // buffered must stay below DEPTH, so a late ack can never overflow the FIFO.
   always_comb begin
      in_bus   = (state_q == BUS);
      credit   = ({1'b0, out_q} + {1'b0, cnt_q}) < (FBITS+2)'(DEPTH);
      stb      = in_bus && (iss_q < len_q) && credit;
      accept   = stb && !wat_i;
      push     = ack_i && (out_q != '0);
      pop      = (cnt_q != '0) && rdy_i;
      last_ack = push && (acks_q == len_q - LBITS'(1));
   end

   // Next-state logic for the transfer FSM, counters and FIFO pointers.
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      len_d   = len_q;
      iss_d   = iss_q;
      acks_d  = acks_q;
      zdone_d = 1'b0;
      out_d   = out_q + (FBITS+1)'(accept) - (FBITS+1)'(push);
      wptr_d  = wptr_q + FBITS'(push);
      rptr_d  = rptr_q + FBITS'(pop);
      cnt_d   = cnt_q + (FBITS+1)'(push) - (FBITS+1)'(pop);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d = BUS;
                  adr_d   = base_i;
                  len_d   = len_i;
                  iss_d   = '0;
                  acks_d  = '0;
               end else begin
                  zdone_d = 1'b1;
               end
            end
         end
         BUS: begin
            if (accept) begin
               adr_d = adr_q + 1'b1;
               iss_d = iss_q + LBITS'(1);
            end
            if (push)     acks_d  = acks_q + LBITS'(1);
            if (last_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any transfer and empties the FIFO.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         adr_q   <= '0;
         len_q   <= '0;
         iss_q   <= '0;
         acks_q  <= '0;
         out_q   <= '0;
         zdone_q <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         acks_q  <= acks_d;
         out_q   <= out_d;
         zdone_q <= zdone_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // FIFO storage; contents need no reset because the count gates visibility.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= dat_i;
   end

   // Bus and stream outputs. The burst flag drops on the strobe for the final
   // word, and done fires in the cycle the final ack arrives.
   always_comb begin
      busy_o = in_bus;
      cyc_o  = in_bus;
      stb_o  = stb;
      we_o   = 1'b0;
      bst_o  = in_bus && ((iss_q + LBITS'(1)) < len_q);
      done_o = zdone_q || (in_bus && last_ack);
      adr_o  = adr_q;
      vld_o  = (cnt_q != '0);
      dat_o  = mem_q[rptr_q];
   end

endmodule

// File: tb/tb_wb_sram_burst_reader.sv
// Scoreboard bench: a one-cycle-latency responder returns data = address.
// Each accepted strobe queues its expected word, and the stream side pops the
// queue and compares the word it receives.
module tb_wb_sram_burst_reader;
   localparam int SBITS = 10;
   localparam int LBITS = 11;
   localparam int DEPTH = 4;

   logic             clk_i = 1'b0, rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic [SBITS-1:0] base_i = '0;
   logic [LBITS-1:0] len_i = '0;
   logic             busy_o, done_o, cyc_o, stb_o, we_o, bst_o;
   logic             ack_i = 1'b0, wat_i = 1'b0;
   logic [SBITS-1:0] adr_o;
   logic [31:0]      dat_i = '0, dat_o;
   logic             vld_o, rdy_i = 1'b1;

   wb_sram_burst_reader dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_i(base_i),
      .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .cyc_o(cyc_o),
      .stb_o(stb_o), .we_o(we_o), .bst_o(bst_o), .ack_i(ack_i),
      .wat_i(wat_i), .adr_o(adr_o), .dat_i(dat_i), .dat_o(dat_o),
      .vld_o(vld_o), .rdy_i(rdy_i)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0, n_err = 0;
   logic [31:0]      exp_q[$];
   logic [SBITS-1:0] exp_adr;
   int               cur_len = 0, str_idx = 0, inflight = 0;
   int               done_cnt = 0, acks_seen = 0, done_base = 0;
   logic             acc_now = 1'b0;
   logic [SBITS-1:0] acc_adr = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Bus/stream monitor and scoreboard, sampled mid-cycle.
   always @(negedge clk_i) begin
      logic [31:0] w;
      if (!rst_i) begin
         if (stb_o && !wat_i) begin
            chk("credit", 32'(inflight < DEPTH), 32'd1);
            chk("adr", 32'(adr_o), 32'(exp_adr));
            chk("bst", 32'(bst_o), 32'(str_idx + 1 < cur_len));
            exp_q.push_back({22'b0, adr_o});
            exp_adr  = exp_adr + 1'b1;
            str_idx++;
            inflight++;
         end
         if (vld_o && rdy_i) begin
            if (exp_q.size() == 0) chk("extra_word", 32'(dat_o), 32'hFFFF_FFFF);
            else begin
               w = exp_q.pop_front();
               chk("data", dat_o, w);
            end
            inflight--;
         end
         if (done_o) done_cnt++;
         if (ack_i) acks_seen++;
      end
      acc_now = stb_o && !wat_i && !rst_i;
      acc_adr = adr_o;
   end

   // Responder: ack one cycle after each accepted strobe.
   always @(posedge clk_i) begin
      #1;
      ack_i = acc_now;
      dat_i = {22'b0, acc_adr};
   end

   task automatic start_xfer(input logic [SBITS-1:0] b, input int n);
      @(posedge clk_i); #1;
      done_base = done_cnt;
      exp_adr = b; cur_len = n; str_idx = 0;
      start_i = 1'b1; base_i = b; len_i = LBITS'(n);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(negedge clk_i);
      if (n == 0) begin
         chk("zlen_done", 32'(done_o), 32'd1);
         chk("zlen_cyc", 32'(cyc_o), 32'd0);
      end else begin
         chk("start_cyc", 32'(cyc_o), 32'd1);
         chk("start_busy", 32'(busy_o), 32'd1);
         chk("start_bst", 32'(bst_o), 32'(n != 1));
         chk("start_adr", 32'(adr_o), 32'(b));
      end
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done_cnt == done_base && k < 200) begin
         @(posedge clk_i); k++;
      end
      chk(tag, 32'(done_cnt > done_base), 32'd1);
      @(negedge clk_i);
      chk({tag, "_cyc_low"}, 32'(cyc_o), 32'd0);
      chk({tag, "_busy_low"}, 32'(busy_o), 32'd0);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk_i); k++;
      end
      repeat (2) @(posedge clk_i);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_vld_low"}, 32'(vld_o), 32'd0);
      chk({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
   endtask

   initial begin
      int a0, k;
      // reset state
      #12;
      chk("rst_busy", 32'(busy_o), 0); chk("rst_cyc", 32'(cyc_o), 0);
      chk("rst_stb", 32'(stb_o), 0);   chk("rst_vld", 32'(vld_o), 0);
      chk("rst_adr", 32'(adr_o), 0);   chk("rst_done", 32'(done_o), 0);
      chk("we_zero", 32'(we_o), 0);
      @(posedge clk_i); #1 rst_i = 1'b0;

      // basic burst
      start_xfer(10'h010, 4);
      wait_done("basic_done");
      drain("basic");
      chk("basic_strobes", 32'(str_idx), 32'd4);

      // ack with nothing outstanding must not push
      @(posedge clk_i); #2 ack_i = 1'b1; dat_i = 32'hDEAD;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("stray_ack_vld", 32'(vld_o), 32'd0);

      // backpressure: credit caps in-flight words at DEPTH
      rdy_i = 1'b0;
      start_xfer(10'h100, 10);
      repeat (20) @(posedge clk_i);
      chk("bp_stall_strobes", 32'(str_idx), 32'd4);
      #1 rdy_i = 1'b1;
      wait_done("bp_done");
      drain("bp");
      chk("bp_strobes", 32'(str_idx), 32'd10);

      // wait states on the second strobe
      a0 = acks_seen;
      start_xfer(10'h200, 3);
      @(posedge clk_i); #1 wat_i = 1'b1;
      @(negedge clk_i);
      chk("wat_adr0", 32'(adr_o), 32'h201); chk("wat_stb0", 32'(stb_o), 1);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("wat_adr1", 32'(adr_o), 32'h201); chk("wat_stb1", 32'(stb_o), 1);
      @(posedge clk_i); #1 wat_i = 1'b0;
      wait_done("wat_done");
      drain("wat");
      chk("wat_acks", 32'(acks_seen - a0), 32'd3);

      // address wrap
      start_xfer(10'h3FE, 4);
      wait_done("wrap_done");
      drain("wrap");

      // zero length
      start_xfer(10'h077, 0);
      @(negedge clk_i);
      chk("zlen_pulse_end", 32'(done_o), 32'd0);
      chk("zlen_idle", 32'(cyc_o), 32'd0);

      // start while busy is ignored
      start_xfer(10'h020, 6);
      @(posedge clk_i); #1 start_i = 1'b1; base_i = 10'h300; len_i = 11'd2;
      @(posedge clk_i); #1 start_i = 1'b0;
      wait_done("busy_done");
      drain("busy");
      chk("busy_strobes", 32'(str_idx), 32'd6);

      // asynchronous reset mid-transfer
      a0 = acks_seen;
      start_xfer(10'h040, 8);
      k = 0;
      while (acks_seen - a0 < 2 && k < 50) begin @(posedge clk_i); k++; end
      chk("rst_wait_acks", 32'(acks_seen - a0 >= 2), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("mid_busy", 32'(busy_o), 0); chk("mid_cyc", 32'(cyc_o), 0);
      chk("mid_stb", 32'(stb_o), 0);   chk("mid_bst", 32'(bst_o), 0);
      chk("mid_vld", 32'(vld_o), 0);   chk("mid_adr", 32'(adr_o), 0);
      chk("mid_done", 32'(done_o), 0);
      exp_q.delete(); inflight = 0; acc_now = 1'b0; ack_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      start_xfer(10'h050, 2);
      wait_done("post_rst_done");
      drain("post_rst");
      chk("post_rst_strobes", 32'(str_idx), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
